// File: rtl/rs_alu_pkg.sv
// Shared constants for the ALU reservation station:
// op codes, RoB tag width and station sizing.
package rs_alu_pkg;

   localparam int ROB_ADDR_W  = 4;
   localparam int RS_ALU_SIZE = 8;
   localparam int RS_IDX_W    = $clog2(RS_ALU_SIZE);

   typedef logic [5:0] op_t;

   localparam op_t OP_NOP   = 6'd0;
   localparam op_t OP_LUI   = 6'd1;
   localparam op_t OP_AUIPC = 6'd2;
   localparam op_t OP_JAL   = 6'd3;
   localparam op_t OP_JALR  = 6'd4;
   localparam op_t OP_BEQ   = 6'd5;
   localparam op_t OP_BNE   = 6'd6;
   localparam op_t OP_BLT   = 6'd7;
   localparam op_t OP_BGE   = 6'd8;
   localparam op_t OP_BLTU  = 6'd9;
   localparam op_t OP_BGEU  = 6'd10;
   localparam op_t OP_ADDI  = 6'd19;
   localparam op_t OP_SLTI  = 6'd20;
   localparam op_t OP_SLTIU = 6'd21;
   localparam op_t OP_XORI  = 6'd22;
   localparam op_t OP_ORI   = 6'd23;
   localparam op_t OP_ANDI  = 6'd24;
   localparam op_t OP_SLLI  = 6'd25;
   localparam op_t OP_SRLI  = 6'd26;
   localparam op_t OP_SRAI  = 6'd27;
   localparam op_t OP_ADD   = 6'd28;
   localparam op_t OP_SUB   = 6'd29;

endpackage

// File: rtl/rs_alu_pick.sv
// Lowest-index priority encoder: index of the first set bit
// plus a flag saying whether any bit was set.
module rs_alu_pick #(
   parameter int N  = 8,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  i_vec,
   output logic [IW-1:0] o_idx,
   output logic          o_found
);

   always_comb begin
      o_idx   = '0;
      o_found = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (i_vec[i]) begin
            o_idx   = IW'(i);
            o_found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rs_alu.sv
// ALU reservation station: holds dispatched ops until both
// operands arrive, then issues the lowest ready entry each cycle.
module rs_alu
   import rs_alu_pkg::*;
#(
   parameter int DEPTH = RS_ALU_SIZE,
   parameter int ROB_W = ROB_ADDR_W
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             rdy_in,
   input  logic             clear_in,
   input  logic             disp_valid,
   input  logic [5:0]       disp_op,
   input  logic [31:0]      disp_vj,
   input  logic [ROB_W-1:0] disp_qj,
   input  logic             disp_qj_busy,
   input  logic [31:0]      disp_vk,
   input  logic [ROB_W-1:0] disp_qk,
   input  logic             disp_qk_busy,
   input  logic [ROB_W-1:0] disp_robid,
   output logic             full,
   input  logic             alu_valid,
   input  logic [ROB_W-1:0] alu_robid,
   input  logic [31:0]      alu_result,
   input  logic             lsb_valid,
   input  logic [ROB_W-1:0] lsb_robid,
   input  logic [31:0]      lsb_result,
   output logic [31:0]      rs1,
   output logic [31:0]      rs2,
   output logic [5:0]       op,
   output logic [ROB_W-1:0] robid
);

   localparam int IW = $clog2(DEPTH);
   localparam int CW = IW + 1;

   logic [DEPTH-1:0] r_busy;
   logic [DEPTH-1:0] r_qj_busy;
   logic [DEPTH-1:0] r_qk_busy;
   logic [5:0]       r_op    [DEPTH];
   logic [31:0]      r_vj    [DEPTH];
   logic [31:0]      r_vk    [DEPTH];
   logic [ROB_W-1:0] r_qj    [DEPTH];
   logic [ROB_W-1:0] r_qk    [DEPTH];
   logic [ROB_W-1:0] r_robid [DEPTH];
   logic [CW-1:0]    r_count;

   logic [DEPTH-1:0] w_ready;
   logic [IW-1:0]    w_free_idx;
   logic [IW-1:0]    w_iss_idx;
   logic             w_free_found;
   logic             w_iss;
   logic             w_disp;
   logic [31:0]      w_vj;
   logic [31:0]      w_vk;
   logic             w_qj_busy;
   logic             w_qk_busy;

   assign full    = (r_count == CW'(DEPTH));
   assign w_ready = r_busy & ~r_qj_busy & ~r_qk_busy;
   assign w_disp  = disp_valid & ~full & w_free_found;

   rs_alu_pick #(.N(DEPTH), .IW(IW)) u_free (
      .i_vec   (~r_busy),
      .o_idx   (w_free_idx),
      .o_found (w_free_found)
   );

   rs_alu_pick #(.N(DEPTH), .IW(IW)) u_ready (
      .i_vec   (w_ready),
      .o_idx   (w_iss_idx),
      .o_found (w_iss)
   );

   // Same-cycle bypass so a dispatch never misses a broadcast
   always_comb begin
      w_vj      = disp_vj;
      w_qj_busy = disp_qj_busy;
      w_vk      = disp_vk;
      w_qk_busy = disp_qk_busy;
      if (disp_qj_busy) begin
         if (alu_valid && alu_robid == disp_qj) begin
            w_vj      = alu_result;
            w_qj_busy = 1'b0;
         end else if (lsb_valid && lsb_robid == disp_qj) begin
            w_vj      = lsb_result;
            w_qj_busy = 1'b0;
         end
      end
      if (disp_qk_busy) begin
         if (alu_valid && alu_robid == disp_qk) begin
            w_vk      = alu_result;
            w_qk_busy = 1'b0;
         end else if (lsb_valid && lsb_robid == disp_qk) begin
            w_vk      = lsb_result;
            w_qk_busy = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         r_busy    <= '0;
         r_qj_busy <= '0;
         r_qk_busy <= '0;
         r_count   <= '0;
         op        <= '0;
         rs1       <= '0;
         rs2       <= '0;
         robid     <= '0;
      end else if (!rdy_in) begin
         op <= '0;
      end else if (clear_in) begin
         r_busy  <= '0;
         r_count <= '0;
         op      <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (r_busy[i] && r_qj_busy[i]) begin
               if (alu_valid && alu_robid == r_qj[i]) begin
                  r_vj[i]      <= alu_result;
                  r_qj_busy[i] <= 1'b0;
               end else if (lsb_valid && lsb_robid == r_qj[i]) begin
                  r_vj[i]      <= lsb_result;
                  r_qj_busy[i] <= 1'b0;
               end
            end
            if (r_busy[i] && r_qk_busy[i]) begin
               if (alu_valid && alu_robid == r_qk[i]) begin
                  r_vk[i]      <= alu_result;
                  r_qk_busy[i] <= 1'b0;
               end else if (lsb_valid && lsb_robid == r_qk[i]) begin
                  r_vk[i]      <= lsb_result;
                  r_qk_busy[i] <= 1'b0;
               end
            end
         end
         if (w_iss) begin
            op                <= r_op[w_iss_idx];
            rs1               <= r_vj[w_iss_idx];
            rs2               <= r_vk[w_iss_idx];
            robid             <= r_robid[w_iss_idx];
            r_busy[w_iss_idx] <= 1'b0;
         end else begin
            op <= '0;
         end
         // Free slot comes from pre-edge busy, so an entry
         // issued this edge is only reusable next cycle
         if (w_disp) begin
            r_busy[w_free_idx]    <= 1'b1;
            r_op[w_free_idx]      <= disp_op;
            r_vj[w_free_idx]      <= w_vj;
            r_qj[w_free_idx]      <= disp_qj;
            r_qj_busy[w_free_idx] <= w_qj_busy;
            r_vk[w_free_idx]      <= w_vk;
            r_qk[w_free_idx]      <= disp_qk;
            r_qk_busy[w_free_idx] <= w_qk_busy;
            r_robid[w_free_idx]   <= disp_robid;
         end
         r_count <= r_count + CW'(w_disp) - CW'(w_iss);
      end
   end

endmodule
